// File: rtl/rng_gen_if.sv
// Bounded-draw handshake bundle for rng_gen.
// Request side and result side, each valid/ready.
interface rng_gen_if #(
   parameter int CW = 4
);
   logic          req_valid;
   logic          req_ready;
   logic          out_valid;
   logic          out_ready;
   logic [CW-1:0] out_value;

   modport master (
      output req_valid,
      output out_ready,
      input  req_ready,
      input  out_valid,
      input  out_value
   );

   modport slave (
      input  req_valid,
      input  out_ready,
      output req_ready,
      output out_valid,
      output out_value
   );
endinterface

// File: rtl/rng_gen.sv
// Parametrised Galois LFSR with seed load, step enable and a
// rejection-sampling bounded-draw engine with capped retries.
module rng_gen #(
   parameter int               WIDTH     = 12,
   parameter logic [WIDTH-1:0] TAPS      = 12'h829,
   parameter logic [WIDTH-1:0] SEED      = 12'hACE,
   parameter int               RANGE     = 10,
   parameter int               CW        = $clog2(RANGE),
   parameter int               MAX_TRIES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             seed_load,
   input  logic [WIDTH-1:0] seed_in,
   output logic [WIDTH-1:0] randy,
   rng_gen_if.slave         drw
);

   localparam int            TW   = $clog2(MAX_TRIES) + 1;
   localparam logic [TW-1:0] LAST = TW'(MAX_TRIES - 1);
   localparam logic [CW:0]   RNG  = (CW + 1)'(RANGE);
   localparam logic [CW-1:0] RLO  = CW'(RANGE);

   typedef enum logic [1:0] {
      IDLE,
      SAMPLE,
      HOLD
   } state_e;

   state_e            state_q, state_d;
   logic [WIDTH-1:0]  lfsr_q, lfsr_d;
   logic [WIDTH-1:0]  step_v;
   logic [TW-1:0]     tries_q, tries_d;
   logic              oval_q, oval_d;
   logic [CW-1:0]     ovalue_q, ovalue_d;
   logic [CW-1:0]     low;

   assign step_v = {1'b0, lfsr_q[WIDTH-1:1]}
                 ^ (lfsr_q[0] ? TAPS : '0);
   assign low    = lfsr_q[CW-1:0];

   // Zero seed is replaced so the lockup state is unreachable.
   always_comb begin
      lfsr_d = lfsr_q;
      if (seed_load) begin
         lfsr_d = (seed_in == '0) ? SEED : seed_in;
      end else if (en || (state_q == SAMPLE)) begin
         lfsr_d = step_v;
      end
   end

   always_comb begin
      state_d  = state_q;
      tries_d  = tries_q;
      oval_d   = oval_q;
      ovalue_d = ovalue_q;
      unique case (state_q)
         IDLE: begin
            if (drw.req_valid) begin
               state_d = SAMPLE;
               tries_d = '0;
            end
         end
         SAMPLE: begin
            if ({1'b0, low} < RNG) begin
               ovalue_d = low;
               oval_d   = 1'b1;
               state_d  = HOLD;
            end else if (tries_q == LAST) begin
               // 2^CW < 2*RANGE, so one subtraction lands in range.
               ovalue_d = low - RLO;
               oval_d   = 1'b1;
               state_d  = HOLD;
            end else begin
               tries_d = tries_q + TW'(1);
            end
         end
         HOLD: begin
            if (drw.out_ready) begin
               oval_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= IDLE;
         lfsr_q   <= SEED;
         tries_q  <= '0;
         oval_q   <= 1'b0;
         ovalue_q <= '0;
      end else begin
         state_q  <= state_d;
         lfsr_q   <= lfsr_d;
         tries_q  <= tries_d;
         oval_q   <= oval_d;
         ovalue_q <= ovalue_d;
      end
   end

   assign randy         = lfsr_q;
   assign drw.req_ready = (state_q == IDLE);
   assign drw.out_valid = oval_q;
   assign drw.out_value = ovalue_q;

endmodule

// File: tb/tb_rng_gen.sv
// Self-checking bench for rng_gen: vector table for the LFSR,
// scoreboard for bounded draws, hand sequences for corner cases.
module tb_rng_gen;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        en = 1'b0;
   logic        seed_load = 1'b0;
   logic [11:0] seed_in = 12'h0;
   logic [11:0] randy;
   logic [11:0] randy2;

   rng_gen_if #(.CW(4)) drw  ();
   rng_gen_if #(.CW(4)) drw2 ();

   rng_gen dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .seed_load (seed_load),
      .seed_in   (seed_in),
      .randy     (randy),
      .drw       (drw)
   );

   rng_gen #(.MAX_TRIES(1)) dut2 (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .seed_load (seed_load),
      .seed_in   (seed_in),
      .randy     (randy2),
      .drw       (drw2)
   );

   always #5 clk = ~clk;

   int n_pass = 0;
   int n_chk  = 0;

   typedef struct {
      logic        en;
      logic        ld;
      logic [11:0] sd;
      logic [11:0] exp;
   } vec_t;

   int          exp_val_q[$];
   int          exp_lat_q[$];
   logic [11:0] model_s;

   task automatic check(input string nm, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      step();
      rst = 1'b1;
      model_s = 12'hACE;
   endtask

   function automatic logic [11:0] lstep(input logic [11:0] s);
      return {1'b0, s[11:1]} ^ (s[0] ? 12'h829 : 12'h000);
   endfunction

   // Reference draw: RANGE 10, 4 tries, en held low.
   task automatic model_draw(input logic [11:0] s0);
      logic [11:0] s;
      int lo;
      s = s0;
      for (int t = 0; t < 4; t++) begin
         lo = int'(s[3:0]);
         if (lo < 10) begin
            exp_val_q.push_back(lo);
            exp_lat_q.push_back(t + 1);
            return;
         end else if (t == 3) begin
            exp_val_q.push_back(lo - 10);
            exp_lat_q.push_back(4);
            return;
         end
         s = lstep(s);
      end
   endtask

   task automatic do_draw(input bit ld, input logic [11:0] sd,
                          input int dly, input bit verbose);
      int lat;
      int ev, el;
      if (ld) begin
         seed_load = 1'b1;
         seed_in   = sd;
         step();
         seed_load = 1'b0;
         model_s   = (sd == 12'h0) ? 12'hACE : sd;
      end
      model_draw(model_s);
      drw.req_valid = 1'b1;
      step();
      drw.req_valid = 1'b0;
      lat = 0;
      while (!drw.out_valid && lat < 10) begin
         step();
         lat++;
      end
      ev = exp_val_q.pop_front();
      el = exp_lat_q.pop_front();
      if (!drw.out_valid) begin
         check("draw_timeout", 32'(drw.out_valid), 32'd1);
      end else begin
         check("draw_value", 32'(drw.out_value), 32'(ev));
         if (verbose) begin
            check("draw_latency", 32'(lat), 32'(el));
            check("draw_ready_low", 32'(drw.req_ready), 32'd0);
         end
      end
      for (int i = 0; i < dly; i++) step();
      drw.out_ready = 1'b1;
      step();
      drw.out_ready = 1'b0;
      if (verbose) begin
         check("release_ready", 32'(drw.req_ready), 32'd1);
         check("release_valid", 32'(drw.out_valid), 32'd0);
      end
      // LFSR advanced once per SAMPLE cycle.
      for (int i = 0; i < el; i++) model_s = lstep(model_s);
   endtask

   vec_t vt[7];

   initial begin
      int bad_zero, bad_rep, bad_mod, bad_rng, bad_hold;
      logic [11:0] ms, hv;
      bit seen[4096];

      drw.req_valid  = 1'b0;
      drw.out_ready  = 1'b0;
      drw2.req_valid = 1'b0;
      drw2.out_ready = 1'b0;

      vt[0] = '{1'b1, 1'b0, 12'h000, 12'h567};
      vt[1] = '{1'b1, 1'b0, 12'h000, 12'hA9A};
      vt[2] = '{1'b0, 1'b1, 12'h123, 12'h123};
      vt[3] = '{1'b0, 1'b1, 12'h000, 12'hACE};
      vt[4] = '{1'b1, 1'b1, 12'h123, 12'h123};
      vt[5] = '{1'b0, 1'b0, 12'h000, 12'h123};
      vt[6] = '{1'b1, 1'b0, 12'h000, 12'h8B8};

      step();
      do_reset();
      check("rst_randy", 32'(randy), 32'hACE);
      check("rst_req_ready", 32'(drw.req_ready), 32'd1);
      check("rst_out_valid", 32'(drw.out_valid), 32'd0);
      check("rst_out_value", 32'(drw.out_value), 32'd0);

      foreach (vt[i]) begin
         en        = vt[i].en;
         seed_load = vt[i].ld;
         seed_in   = vt[i].sd;
         step();
         check($sformatf("vec%0d_randy", i), 32'(randy), 32'(vt[i].exp));
      end
      en        = 1'b0;
      seed_load = 1'b0;
      seed_in   = 12'h0;

      // Full period from reset.
      do_reset();
      bad_zero = 0;
      bad_rep  = 0;
      bad_mod  = 0;
      foreach (seen[i]) seen[i] = 1'b0;
      seen[12'hACE] = 1'b1;
      ms = 12'hACE;
      en = 1'b1;
      for (int c = 1; c <= 4095; c++) begin
         step();
         ms = lstep(ms);
         if (randy !== ms) bad_mod++;
         if (c < 4095) begin
            if (randy == 12'h0) bad_zero++;
            if (seen[randy]) bad_rep++;
            seen[randy] = 1'b1;
         end
      end
      en = 1'b0;
      check("period_return", 32'(randy), 32'hACE);
      check("period_nozero", 32'(bad_zero), 32'd0);
      check("period_norepeat", 32'(bad_rep), 32'd0);
      check("period_model", 32'(bad_mod), 32'd0);

      // Rejection draw: 0xACE rejected, 0x567 gives 7.
      do_reset();
      do_draw(1'b0, 12'h0, 0, 1'b1);

      // Fallback with a single try: 14 - 10.
      do_reset();
      drw2.req_valid = 1'b1;
      step();
      drw2.req_valid = 1'b0;
      check("fb_valid_early", 32'(drw2.out_valid), 32'd0);
      step();
      check("fb_valid", 32'(drw2.out_valid), 32'd1);
      check("fb_value", 32'(drw2.out_value), 32'd4);
      drw2.out_ready = 1'b1;
      step();
      drw2.out_ready = 1'b0;
      check("fb_release", 32'(drw2.req_ready), 32'd1);

      // Backpressure: result held stable while out_ready low.
      do_reset();
      drw.req_valid = 1'b1;
      step();
      drw.req_valid = 1'b0;
      step();
      step();
      check("hold_valid", 32'(drw.out_valid), 32'd1);
      hv = 12'(drw.out_value);
      check("hold_value", 32'(hv), 32'd7);
      bad_hold = 0;
      for (int i = 0; i < 5; i++) begin
         drw.req_valid = 1'b1;
         step();
         if (drw.out_value !== hv[3:0]) bad_hold++;
         if (drw.req_ready !== 1'b0) bad_hold++;
         if (drw.out_valid !== 1'b1) bad_hold++;
      end
      drw.req_valid = 1'b0;
      check("hold_stable", 32'(bad_hold), 32'd0);
      drw.out_ready = 1'b1;
      step();
      drw.out_ready = 1'b0;
      check("hold_release", 32'(drw.req_ready), 32'd1);

      // Seed load in SAMPLE wins over the step.
      do_reset();
      drw.req_valid = 1'b1;
      step();
      drw.req_valid = 1'b0;
      seed_load = 1'b1;
      seed_in   = 12'h123;
      step();
      seed_load = 1'b0;
      check("ld_sample_randy", 32'(randy), 32'h123);
      check("ld_sample_busy", 32'(drw.out_valid), 32'd0);
      step();
      check("ld_sample_valid", 32'(drw.out_valid), 32'd1);
      check("ld_sample_value", 32'(drw.out_value), 32'd3);
      drw.out_ready = 1'b1;
      step();
      drw.out_ready = 1'b0;

      // Reset during SAMPLE discards the draw.
      do_reset();
      drw.req_valid = 1'b1;
      step();
      drw.req_valid = 1'b0;
      check("mid_in_sample", 32'(drw.req_ready), 32'd0);
      rst = 1'b0;
      step();
      rst = 1'b1;
      check("mid_rst_ready", 32'(drw.req_ready), 32'd1);
      check("mid_rst_valid", 32'(drw.out_valid), 32'd0);
      check("mid_rst_randy", 32'(randy), 32'hACE);
      bad_hold = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (drw.out_valid !== 1'b0) bad_hold++;
      end
      check("mid_rst_quiet", 32'(bad_hold), 32'd0);

      // Random draws against the scoreboard.
      do_reset();
      bad_rng = 0;
      for (int i = 0; i < 1000; i++) begin
         do_draw(1'b1, 12'($urandom), int'($urandom_range(0, 2)), 1'b0);
         if (drw.out_value >= 4'd10) bad_rng++;
      end
      check("rand_in_range", 32'(bad_rng), 32'd0);
      check("rand_sb_empty", 32'(exp_val_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
